// File: rtl/sdiv32_pkg.sv
// Shared types, constants and helpers for the sdiv32_front signed-divide wrapper.
package sdiv32_pkg;

    localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

    // Per-request context carried alongside the divider core pipeline; the tag
    // travels in a parallel array because its width is a module parameter.
    typedef struct packed {
        logic        valid;
        logic        sign_q;
        logic        sign_r;
        logic        dz;
        logic [31:0] a;
    } flight_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/sdiv32_front_if.sv
// Request, result and divider-core signals of sdiv32_front; slave is the block's view.
interface sdiv32_front_if #(
    parameter int unsigned ID_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_a;
    logic [31:0]     in_b;
    logic [ID_W-1:0] in_id;

    logic [63:0]     core_x;
    logic [31:0]     core_d;
    logic [31:0]     core_q;
    logic [31:0]     core_r;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_q;
    logic [31:0]     out_r;
    logic [ID_W-1:0] out_id;
    logic            out_dz;

    modport master (
        output in_valid, in_a, in_b, in_id, out_ready, core_q, core_r,
        input  in_ready, core_x, core_d, out_valid, out_q, out_r, out_id, out_dz
    );

    modport slave (
        input  in_valid, in_a, in_b, in_id, out_ready, core_q, core_r,
        output in_ready, core_x, core_d, out_valid, out_q, out_r, out_id, out_dz
    );

endinterface

// File: rtl/sdiv32_res_fifo.sv
// Result buffer for sdiv32_front: power-of-two depth FIFO with a combinational head.
module sdiv32_res_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign empty_o = (count_q == '0);
    assign do_rd   = rd_en_i & ~empty_o;
    assign do_wr   = wr_en_i & ((count_q != CW'(DEPTH)) | do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q;
        if (do_wr & ~do_rd) begin
            count_d = count_q + CW'(1);
        end else if (~do_wr & do_rd) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Empty reads as zero so the result outputs are clean during and after reset.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/sdiv32_front.sv
// Signed front end for a pipelined unsigned 64/32 divider core with credit-based result buffering.
// Define SDIV32_SIGNED_EN for signed semantics; otherwise operands pass through unsigned.
module sdiv32_front
    import sdiv32_pkg::*;
#(
    parameter int unsigned CORE_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_W       = 4
) (
    input  logic          clk,
    input  logic          rst,
    sdiv32_front_if.slave bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RW = 32 + 32 + ID_W + 1;

    flight_t         pipe_q [CORE_LAT];
    logic [ID_W-1:0] pid_q  [CORE_LAT];
    flight_t         issue_d;
    flight_t         tail;
    logic [ID_W-1:0] tail_id;
    logic            accept;
    logic            in_ready;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic [31:0]     res_q, res_r;
    logic [RW-1:0]   wr_data, rd_data;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < CORE_LAT; i++) begin
            inflight = inflight + CW'(pipe_q[i].valid);
        end
    end

    // In-flight entries hold a reserved FIFO slot, so the FIFO can never overflow.
    assign in_ready     = ~rst & ((fifo_count + inflight) < CW'(FIFO_DEPTH));
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid & in_ready;

    always_comb begin
        issue_d     = '0;
        bus.core_x  = '0;
        bus.core_d  = 32'd1;
        if (accept) begin
            issue_d.valid = 1'b1;
            issue_d.dz    = (bus.in_b == '0);
            issue_d.a     = bus.in_a;
`ifdef SDIV32_SIGNED_EN
            issue_d.sign_q = bus.in_a[31] ^ bus.in_b[31];
            issue_d.sign_r = bus.in_a[31];
            bus.core_x     = {32'd0, bus.in_a[31] ? neg32(bus.in_a) : bus.in_a};
            bus.core_d     = bus.in_b[31] ? neg32(bus.in_b) : bus.in_b;
`else
            bus.core_x     = {32'd0, bus.in_a};
            bus.core_d     = bus.in_b;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CORE_LAT; i++) begin
                pipe_q[i] <= '0;
                pid_q[i]  <= '0;
            end
        end else begin
            pipe_q[0] <= issue_d;
            pid_q[0]  <= bus.in_id;
            for (int unsigned i = 1; i < CORE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
                pid_q[i]  <= pid_q[i-1];
            end
        end
    end

    assign tail    = pipe_q[CORE_LAT-1];
    assign tail_id = pid_q[CORE_LAT-1];

    always_comb begin
        res_q = tail.sign_q ? neg32(bus.core_q) : bus.core_q;
        res_r = tail.sign_r ? neg32(bus.core_r) : bus.core_r;
        if (tail.dz) begin
            res_q = DZ_QUOTIENT;
            res_r = tail.a;
        end
    end

    assign wr_data = {tail.dz, tail_id, res_r, res_q};

    sdiv32_res_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (tail.valid),
        .wr_data_i (wr_data),
        .rd_en_i   (bus.out_ready),
        .rd_data_o (rd_data),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign bus.out_valid = ~fifo_empty;
    assign {bus.out_dz, bus.out_id, bus.out_r, bus.out_q} = rd_data;

endmodule
